// File: rtl/iob_arb_pkg.sv
// iob_arb_pkg: return-tag type, wsel encodings and one-hot decode shared by the io_buffer port arbiter.
package iob_arb_pkg;
  localparam int ID_W = 2;
  localparam logic WSEL_RD = 1'b1;
  localparam logic WSEL_WR = 1'b0;
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            pad;
  } tag_t;
  function automatic logic [ID_W-1:0] oh2idx(input logic [3:0] oh);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r = r | (oh[i] ? ID_W'(i) : '0);
    return r;
  endfunction
endpackage

// File: rtl/iob_rr_arbiter.sv
// iob_rr_arbiter: N-way round-robin pick; the search starts at the pointer, which moves past the winner on i_adv.
module iob_rr_arbiter import iob_arb_pkg::*; #(
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  input  logic         i_adv,
  output logic [N-1:0] o_gnt
);
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_idx;
  logic [N-1:0] w_rot;
  logic [N-1:0] w_lsb;
  // rotate so the pointer sits at bit 0, take the lowest set bit, rotate back
  assign w_rot = N'({i_req, i_req} >> r_ptr);
  assign w_lsb = w_rot & (~w_rot + 1'b1);
  assign o_gnt = N'(({w_lsb, w_lsb} << r_ptr) >> N);
  assign w_idx = oh2idx(4'(o_gnt));
  always_ff @(posedge i_clk) begin
    if (i_rst) r_ptr <= '0;
    else if (i_adv) r_ptr <= (w_idx == ID_W'(N - 1)) ? '0 : w_idx + 1'b1;
  end
endmodule

// File: rtl/iob_port_arbiter.sv
// iob_port_arbiter: shares io_buffer's internal port between NUM_RD read/pad requesters and one writer,
// issuing registered commands and routing returned data back in grant order via a tag pipe.
module iob_port_arbiter import iob_arb_pkg::*; #(
  parameter int NUM_RD     = 2,
  parameter int AW         = 12,
  parameter int DW         = 256,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ext_en,
  input  logic [NUM_RD-1:0]    i_rd_req,
  input  logic [NUM_RD*AW-1:0] i_rd_addr,
  input  logic [NUM_RD-1:0]    i_rd_pad,
  output logic [NUM_RD-1:0]    o_rd_gnt,
  input  logic                 i_wr_req,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic [DW-1:0]        i_wr_data,
  output logic                 o_wr_gnt,
  output logic [AW-1:0]        o_iob_raddr,
  output logic                 o_iob_rd_en,
  output logic                 o_iob_pad_en,
  output logic [AW-1:0]        o_iob_waddr,
  output logic                 o_iob_wr_en,
  output logic [DW-1:0]        o_iob_wdat,
  output logic                 o_wsel,
  input  logic [DW-1:0]        i_mdata,
  input  logic                 i_mdata_vld,
  output logic [DW-1:0]        o_rd_data,
  output logic [NUM_RD-1:0]    o_rd_vld
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [NUM_RD-1:0] w_rr_gnt;
  logic              w_rd_any, w_rd_win, w_wr_win, w_rd_pad;
  logic [AW-1:0]     w_rd_addr;
  logic [SW-1:0]     r_starve;
  tag_t              r_cmd_tag;
  tag_t              r_tag [RD_LAT];
  tag_t              w_exit;
  iob_rr_arbiter #(.N(NUM_RD)) u_rr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req (i_rd_req),
    .i_adv (w_rd_win),
    .o_gnt (w_rr_gnt)
  );
  assign w_rd_any = |i_rd_req;
  // the writer has priority until pending reads have lost STARVE_MAX cycles in a row
  assign w_rd_win = !i_ext_en && w_rd_any && (!i_wr_req || r_starve >= SW'(STARVE_MAX));
  assign w_wr_win = !i_ext_en && i_wr_req && !w_rd_win;
  assign o_rd_gnt = w_rd_win ? w_rr_gnt : '0;
  assign o_wr_gnt = w_wr_win;
  assign w_exit   = r_tag[RD_LAT-1];
  always_comb begin
    w_rd_addr = '0;
    w_rd_pad  = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_rd_addr = w_rd_addr | (i_rd_addr[k*AW +: AW] & {AW{w_rr_gnt[k]}});
      w_rd_pad  = w_rd_pad | (i_rd_pad[k] & w_rr_gnt[k]);
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve     <= '0;
      o_iob_raddr  <= '0;
      o_iob_rd_en  <= 1'b0;
      o_iob_pad_en <= 1'b0;
      o_iob_waddr  <= '0;
      o_iob_wr_en  <= 1'b0;
      o_iob_wdat   <= '0;
      o_wsel       <= WSEL_RD;
      r_cmd_tag    <= '0;
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
      o_rd_data    <= '0;
      o_rd_vld     <= '0;
    end else begin
      r_starve     <= w_rd_win ? '0 : (w_rd_any && r_starve != SW'(STARVE_MAX)) ? r_starve + 1'b1 : r_starve;
      o_iob_wr_en  <= w_wr_win;
      o_iob_rd_en  <= w_rd_win && !w_rd_pad;
      o_iob_pad_en <= w_rd_win && w_rd_pad;
      o_wsel       <= w_wr_win ? WSEL_WR : WSEL_RD;
      if (w_wr_win) begin
        o_iob_waddr <= i_wr_addr;
        o_iob_wdat  <= i_wr_data;
      end
      if (w_rd_win) o_iob_raddr <= w_rd_addr;
      r_cmd_tag <= '{vld: w_rd_win, id: oh2idx(4'(w_rr_gnt)), pad: w_rd_pad};
      r_tag[0]  <= r_cmd_tag;
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
      o_rd_vld  <= w_exit.vld ? NUM_RD'(1) << w_exit.id : '0;
      o_rd_data <= (w_exit.vld && !w_exit.pad) ? i_mdata : '0;
    end
  end
  a_rd_pad_excl: assert property (@(posedge i_clk) disable iff (i_rst) !(o_iob_rd_en && o_iob_pad_en));
  a_one_cmd:     assert property (@(posedge i_clk) disable iff (i_rst) $onehot0({o_iob_rd_en, o_iob_pad_en, o_iob_wr_en}));
  a_mdata_vld:   assert property (@(posedge i_clk) disable iff (i_rst) (RD_LAT != 1) || (i_mdata_vld == w_exit.vld));
  a_gnt_req:     assert property (@(posedge i_clk) !(|(o_rd_gnt & ~i_rd_req)) && !(o_wr_gnt && !i_wr_req));
endmodule

// File: tb/tb_iob_port_arbiter.sv
// tb_iob_port_arbiter: drives an RD_LAT=1 and an RD_LAT=2 arbiter with identical requests; a grant/memory
// reference model fills a return scoreboard that per-instance monitors drain whenever o_rd_vld fires.
module tb_iob_port_arbiter;
  localparam int NUM_RD = 2, AW = 12, DW = 256, SM = 8;
  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            at;
  } ret_t;
  logic clk = 0, rst = 1, ext_en = 0;
  logic [NUM_RD-1:0] rd_req = '0, rd_pad = '0;
  logic [NUM_RD*AW-1:0] rd_addr = '0;
  logic wr_req = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  int checks = 0, errors = 0, cyc = 0;
  ret_t exq[$];
  logic [NUM_RD-1:0] exp_rg = '0;
  logic exp_wg = 0, exp_prev_rst = 1;
  int exp_kind = 0, nxt_kind = 0;
  logic [AW-1:0] exp_addr = '0, nxt_addr = '0;
  logic [DW-1:0] exp_wdat = '0, nxt_wdat = '0;
  int ptr = 0, starve = 0;
  bit last_rst = 1, served_wr = 0;
  bit [NUM_RD-1:0] served_rd = '0;
  logic [DW-1:0] mm [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input int a);
    return a == 12'h012 ? {32{8'hA5}} : {8{32'(a) * 32'h9E3779B1 ^ 32'h0F0F1234}};
  endfunction

  // {wr_en, rd_en, pad_en, wsel} for idle / write / read / pad
  function automatic logic [3:0] cmd_bits(input int k);
    return k == 1 ? 4'b1000 : k == 2 ? 4'b0101 : k == 3 ? 4'b0011 : 4'b0001;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int L = g + 1;
    logic [NUM_RD-1:0] rg, rdv;
    logic wg, ren, pen, wen, ws, mv = 0;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd, rdd, md = '0;
    logic [DW-1:0] emem [int];
    logic srd [L], spad [L];
    logic [DW-1:0] sdat [L];
    int rp = 0;
    iob_port_arbiter #(.NUM_RD(NUM_RD), .AW(AW), .DW(DW), .RD_LAT(L), .STARVE_MAX(SM)) dut (
      .i_clk(clk), .i_rst(rst), .i_ext_en(ext_en),
      .i_rd_req(rd_req), .i_rd_addr(rd_addr), .i_rd_pad(rd_pad), .o_rd_gnt(rg),
      .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_gnt(wg),
      .o_iob_raddr(ra), .o_iob_rd_en(ren), .o_iob_pad_en(pen), .o_iob_waddr(wa),
      .o_iob_wr_en(wen), .o_iob_wdat(wd), .o_wsel(ws),
      .i_mdata(md), .i_mdata_vld(mv), .o_rd_data(rdd), .o_rd_vld(rdv)
    );
    // io_buffer stand-in: reads sample memory at the command edge and appear L cycles later
    always @(posedge clk) begin
      for (int i = L - 1; i > 0; i--) begin
        srd[i] = srd[i-1]; spad[i] = spad[i-1]; sdat[i] = sdat[i-1];
      end
      srd[0] = !rst && ren;
      spad[0] = !rst && pen;
      sdat[0] = emem.exists(int'(ra)) ? emem[int'(ra)] : init_word(int'(ra));
      if (rst) for (int i = 0; i < L; i++) begin srd[i] = 0; spad[i] = 0; end
      if (wen) emem[int'(wa)] = wd;
    end
    always @(negedge clk) begin
      md = (cyc > 0 && srd[L-1]) ? sdat[L-1] : ({8{$urandom}} | 256'd1);
      mv = cyc > 0 && (srd[L-1] || spad[L-1]);
    end
    always @(negedge clk) begin
      #2;
      checks++;
      if (rg !== exp_rg || wg !== exp_wg) begin
        errors++;
        $display("FAIL gnt L=%0d cyc=%0d got rd=%b wr=%b exp rd=%b wr=%b", L, cyc, rg, wg, exp_rg, exp_wg);
      end
      checks++;
      if ({wen, ren, pen, ws} !== cmd_bits(exp_kind) || (exp_kind == 2 && ra !== exp_addr)
          || (exp_kind == 1 && (wa !== exp_addr || wd !== exp_wdat))) begin
        errors++;
        $display("FAIL cmd L=%0d cyc=%0d got we/re/pe/ws=%b ra=%h wa=%h exp %b addr=%h", L, cyc,
                 {wen, ren, pen, ws}, ra, wa, cmd_bits(exp_kind), exp_addr);
      end
      if (exp_prev_rst) begin
        checks++;
        if (rdv !== '0 || rdd !== '0) begin
          errors++;
          $display("FAIL rstout L=%0d cyc=%0d got vld=%b data=%h exp 0", L, cyc, rdv, rdd);
        end
      end
    end
    always @(negedge clk) begin
      ret_t e;
      #3;
      if (rdv !== '0) begin
        checks++;
        if (rp >= exq.size()) begin
          errors++;
          $display("FAIL ret L=%0d cyc=%0d got unexpected vld=%b", L, cyc, rdv);
        end else begin
          e = exq[rp];
          rp++;
          if (rdv !== NUM_RD'(1) << e.id || rdd !== e.data || cyc != e.at + 2 + L) begin
            errors++;
            $display("FAIL ret L=%0d cyc=%0d got vld=%b data=%h exp vld=%b data=%h at cyc %0d",
                     L, cyc, rdv, rdd, NUM_RD'(1) << e.id, e.data, e.at + 2 + L);
          end
        end
      end
      while (rp < exq.size() && exq[rp].at + 2 + L < cyc) begin
        checks++;
        errors++;
        $display("FAIL ret L=%0d cyc=%0d got nothing exp id=%0d due at cyc %0d", L, cyc, exq[rp].id, exq[rp].at + 2 + L);
        rp++;
      end
      if (rst) rp = exq.size();
    end
  end

  task automatic tick(input int prd, input int pwr, input int ppad, input bit ext_v, input bit rst_v,
                      input int fa, input logic [NUM_RD-1:0] rmask);
    int win;
    bit rd_any;
    logic [AW-1:0] a;
    @(negedge clk);
    rst = rst_v;
    ext_en = ext_v;
    for (int k = 0; k < NUM_RD; k++) begin
      if (served_rd[k] || rst_v) rd_req[k] = 0;
      if (!rd_req[k] && !rst_v && rmask[k] && $urandom_range(99) < prd) begin
        rd_req[k] = 1;
        rd_pad[k] = $urandom_range(99) < ppad;
        rd_addr[k*AW +: AW] = fa >= 0 ? AW'(fa) : AW'($urandom_range(63));
      end
    end
    if (served_wr || rst_v) wr_req = 0;
    if (!wr_req && !rst_v && $urandom_range(99) < pwr) begin
      wr_req = 1;
      wr_addr = fa >= 0 ? AW'(fa) : AW'($urandom_range(63));
      for (int j = 0; j < 8; j++) wr_data[j*32 +: 32] = $urandom;
    end
    served_rd = '0;
    served_wr = 0;
    #1;
    exp_kind = nxt_kind; exp_addr = nxt_addr; exp_wdat = nxt_wdat; exp_prev_rst = last_rst;
    exp_rg = '0; exp_wg = 0; nxt_kind = 0; last_rst = rst_v;
    rd_any = |rd_req;
    win = -1;
    if (!rst_v && !ext_v && rd_any && (!wr_req || starve >= SM))
      for (int i = NUM_RD - 1; i >= 0; i--) if (rd_req[(ptr + i) % NUM_RD]) win = (ptr + i) % NUM_RD;
    if (rst_v) begin
      ptr = 0;
      starve = 0;
    end else if (win >= 0) begin
      exp_rg[win] = 1;
      served_rd[win] = 1;
      ptr = (win + 1) % NUM_RD;
      starve = 0;
      a = rd_addr[win*AW +: AW];
      nxt_kind = rd_pad[win] ? 3 : 2;
      nxt_addr = a;
      exq.push_back('{win, rd_pad[win] ? '0 : (mm.exists(int'(a)) ? mm[int'(a)] : init_word(int'(a))), cyc});
    end else begin
      if (!ext_v && wr_req) begin
        exp_wg = 1;
        served_wr = 1;
        nxt_kind = 1;
        nxt_addr = wr_addr;
        nxt_wdat = wr_data;
        mm[int'(wr_addr)] = wr_data;
      end
      if (rd_any && starve < SM) starve++;
    end
  endtask

  initial begin
    repeat (3) tick(0, 0, 0, 0, 1, -1, '0);
    tick(100, 0, 0, 0, 0, 12'h012, 2'b01);
    repeat (5) tick(0, 0, 0, 0, 0, -1, '0);
    repeat (4) tick(100, 0, 0, 0, 0, -1, 2'b11);
    repeat (5) tick(0, 0, 0, 0, 0, -1, '0);
    repeat (12) tick(100, 100, 0, 0, 0, -1, 2'b01);
    repeat (5) tick(0, 0, 0, 0, 0, -1, '0);
    tick(100, 0, 100, 0, 0, -1, 2'b10);
    repeat (5) tick(0, 0, 0, 0, 0, -1, '0);
    tick(0, 100, 0, 0, 0, 12'h3FF, '0);
    tick(100, 0, 0, 0, 0, 12'h3FF, 2'b01);
    repeat (5) tick(0, 0, 0, 0, 0, -1, '0);
    repeat (3) tick(100, 100, 0, 1, 0, -1, 2'b11);
    repeat (6) tick(0, 0, 0, 0, 0, -1, '0);
    repeat (3) tick(100, 0, 0, 0, 0, -1, 2'b11);
    tick(0, 0, 0, 0, 1, -1, '0);
    repeat (6) tick(0, 0, 0, 0, 0, -1, '0);
    repeat (400) tick(60, 40, 20, $urandom_range(9) == 0, $urandom_range(59) == 0, -1, 2'b11);
    repeat (10) tick(0, 0, 0, 0, 0, -1, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
